// File: rtl/clock_pkg.sv
// Shared BCD limits and digit type for the time-of-day counter.
`default_nettype none

package clock_pkg;
  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_H_MAX       = 4'd5;
  localparam bcd_t DIG_MAX         = 4'd9;
  localparam bcd_t HOUR_H_MAX      = 4'd2;
  localparam bcd_t HOUR_L_MAX_AT_2 = 4'd3;
endpackage

`default_nettype wire

// File: rtl/bcd_sixty_counter.sv
// Two-digit BCD 00..59 counter with sanitised parallel load; used for seconds and minutes.
`default_nettype none

module bcd_sixty_counter
  import clock_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [3:0] load_L,
  input  logic [3:0] load_H,
  output logic [3:0] L,
  output logic [3:0] H,
  output logic       carry
);

  logic load_ok;

  assign load_ok = (load_H <= SEC_H_MAX) && (load_L <= DIG_MAX);
  assign carry   = inc && (H == SEC_H_MAX) && (L == DIG_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      L <= '0;
      H <= '0;
    end else if (load) begin
      // An out-of-range field loads as 00 rather than a partially valid value.
      L <= load_ok ? load_L : '0;
      H <= load_ok ? load_H : '0;
    end else if (inc) begin
      if (L == DIG_MAX) begin
        L <= '0;
        H <= (H == SEC_H_MAX) ? '0 : H + 4'd1;
      end else begin
        L <= L + 4'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/auto_clocking.sv
// Free-running HH:MM:SS BCD clock with switch-triggered load and a one-second prescaler.
`default_nettype none

module auto_clocking
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int PRE_W    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw0,
  input  logic       sw1,
  input  logic [3:0] manual_secL,
  input  logic [3:0] manual_secH,
  input  logic [3:0] manual_minL,
  input  logic [3:0] manual_minH,
  input  logic [3:0] manual_hourL,
  input  logic [3:0] manual_hourH,
  output logic [3:0] secL,
  output logic [3:0] secH,
  output logic [3:0] minL,
  output logic [3:0] minH,
  output logic [3:0] hourL,
  output logic [3:0] hourH,
  output logic       sec_tick,
  output logic       day_wrap
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic             sw0_s1, sw0_s2, sw0_s3;
  logic             sw1_s1, sw1_s2;
  logic [PRE_W-1:0] pre;
  logic             rise, load, tick_now;
  logic             sec_carry, min_carry;
  logic             hour_ok;

  assign rise     = sw0_s2 & ~sw0_s3;
  assign load     = rise & sw1_s2;
  assign tick_now = sw0_s2 & sw0_s3 & (pre == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw0_s1 <= 1'b0;
      sw0_s2 <= 1'b0;
      sw0_s3 <= 1'b0;
      sw1_s1 <= 1'b0;
      sw1_s2 <= 1'b0;
    end else begin
      sw0_s1 <= sw0;
      sw0_s2 <= sw0_s1;
      sw0_s3 <= sw0_s2;
      sw1_s1 <= sw1;
      sw1_s2 <= sw1_s1;
    end
  end

  // The run edge itself restarts the second, so the first tick lands TICK_DIV cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (!sw0_s2 || rise || tick_now) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  bcd_sixty_counter u_sec (
    .clk    (clk),
    .rst    (rst),
    .inc    (tick_now),
    .load   (load),
    .load_L (manual_secL),
    .load_H (manual_secH),
    .L      (secL),
    .H      (secH),
    .carry  (sec_carry)
  );

  bcd_sixty_counter u_min (
    .clk    (clk),
    .rst    (rst),
    .inc    (sec_carry),
    .load   (load),
    .load_L (manual_minL),
    .load_H (manual_minH),
    .L      (minL),
    .H      (minH),
    .carry  (min_carry)
  );

  assign hour_ok = (manual_hourH <= HOUR_H_MAX) && (manual_hourL <= DIG_MAX) &&
                   !((manual_hourH == HOUR_H_MAX) && (manual_hourL > HOUR_L_MAX_AT_2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hourL <= '0;
      hourH <= '0;
    end else if (load) begin
      hourL <= hour_ok ? manual_hourL : '0;
      hourH <= hour_ok ? manual_hourH : '0;
    end else if (min_carry) begin
      if ((hourH == HOUR_H_MAX) && (hourL == HOUR_L_MAX_AT_2)) begin
        hourL <= '0;
        hourH <= '0;
      end else if (hourL == DIG_MAX) begin
        hourL <= '0;
        hourH <= hourH + 4'd1;
      end else begin
        hourL <= hourL + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
    end else begin
      sec_tick <= tick_now;
      day_wrap <= min_carry && (hourH == HOUR_H_MAX) && (hourL == HOUR_L_MAX_AT_2);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_auto_clocking.sv
// Self-checking bench for auto_clocking: seconds-of-day reference model, scripted and random loads.
`default_nettype none

module tb_auto_clocking;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw0 = 1'b0;
  logic       sw1 = 1'b0;
  logic [3:0] m_sL = '0, m_sH = '0, m_mL = '0, m_mH = '0, m_hL = '0, m_hH = '0;
  logic [3:0] secL, secH, minL, minH, hourL, hourH;
  logic       sec_tick, day_wrap;
  logic [25:0] obs;

  int errors = 0;
  int checks = 0;

  // Reference model state: time as seconds of day, cycles since load/resume.
  int exp_secs = 0;
  int k = 0;
  logic exp_tick = 1'b0;
  logic exp_wrap = 1'b0;

  auto_clocking #(.TICK_DIV(TD), .PRE_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw0          (sw0),
    .sw1          (sw1),
    .manual_secL  (m_sL),
    .manual_secH  (m_sH),
    .manual_minL  (m_mL),
    .manual_minH  (m_mH),
    .manual_hourL (m_hL),
    .manual_hourH (m_hH),
    .secL         (secL),
    .secH         (secH),
    .minL         (minL),
    .minH         (minH),
    .hourL        (hourL),
    .hourH        (hourH),
    .sec_tick     (sec_tick),
    .day_wrap     (day_wrap)
  );

  always #5 clk = ~clk;

  assign obs = {hourH, hourL, minH, minL, secH, secL, sec_tick, day_wrap};

  function automatic logic [25:0] exp_vec();
    int h, m, s;
    h = exp_secs / 3600;
    m = (exp_secs / 60) % 60;
    s = exp_secs % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            exp_tick, exp_wrap};
  endfunction

  function automatic int san_secs(input logic [3:0] hh, hl, mh, ml, sh, sl);
    int h, m, s;
    s = (sh > 5 || sl > 9) ? 0 : int'(sh) * 10 + int'(sl);
    m = (mh > 5 || ml > 9) ? 0 : int'(mh) * 10 + int'(ml);
    h = (hh > 2 || hl > 9 || (hh == 2 && hl > 3)) ? 0 : int'(hh) * 10 + int'(hl);
    return h * 3600 + m * 60 + s;
  endfunction

  // One clock edge; when running, every TD-th cycle since load/resume is one second.
  task automatic advance(input logic running);
    @(posedge clk);
    #1;
    exp_tick = 1'b0;
    exp_wrap = 1'b0;
    if (running) begin
      k++;
      if (k % TD == 0) begin
        exp_secs = (exp_secs + 1) % 86400;
        exp_tick = 1'b1;
        exp_wrap = (exp_secs == 0);
      end
    end
  endtask

  // Stops the clock, presents digits, raises sw0; returns just after the 3rd edge.
  task automatic do_load(input logic [3:0] hh, hl, mh, ml, sh, sl, input logic set);
    sw0 = 1'b0;
    repeat (4) advance(1'b0);
    m_hH = hh; m_hL = hl; m_mH = mh; m_mL = ml; m_sH = sh; m_sL = sl;
    sw1 = set;
    sw0 = 1'b1;
    advance(1'b0);
    advance(1'b0);
    advance(1'b0);
    k = 0;
    if (set) exp_secs = san_secs(hh, hl, mh, ml, sh, sl);
  endtask

  task automatic test_reset();
    #2;
    if (obs !== 26'd0) begin
      errors++;
      $display("FAIL reset: got %h expected %h", obs, 26'd0);
    end
    checks++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_load_and_tick();
    do_load(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 1'b1);
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL load_12_34_56: got %h expected %h", obs, exp_vec());
    end
    checks++;
    repeat (5) begin
      advance(1'b1);
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL first_tick: got %h expected %h", obs, exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_day_wrap();
    do_load(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9, 1'b1);
    repeat (5) begin
      advance(1'b1);
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL day_wrap: got %h expected %h", obs, exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_carries();
    logic [23:0] tbl [3];
    tbl[0] = 24'h095959;
    tbl[1] = 24'h195959;
    tbl[2] = 24'h000059;
    for (int i = 0; i < 3; i++) begin
      do_load(tbl[i][23:20], tbl[i][19:16], tbl[i][15:12], tbl[i][11:8],
              tbl[i][7:4], tbl[i][3:0], 1'b1);
      repeat (4) advance(1'b1);
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL carry_%0d: got %h expected %h", i, obs, exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_sanitise();
    do_load(4'd2, 4'd5, 4'd4, 4'd2, 4'd7, 4'd0, 1'b1);
    if (obs !== {24'h004200, 2'b00}) begin
      errors++;
      $display("FAIL sanitise: got %h expected %h", obs, {24'h004200, 2'b00});
    end
    checks++;
  endtask

  task automatic test_no_load_resume();
    do_load(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 1'b1);
    sw0 = 1'b0;
    advance(1'b1);
    advance(1'b1);
    advance(1'b0);
    advance(1'b0);
    do_load(4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 1'b0);
    if (obs !== {24'h000005, 2'b00}) begin
      errors++;
      $display("FAIL no_load: got %h expected %h", obs, {24'h000005, 2'b00});
    end
    checks++;
    repeat (4) advance(1'b1);
    if (obs !== {24'h000006, 2'b10}) begin
      errors++;
      $display("FAIL resume_tick: got %h expected %h", obs, {24'h000006, 2'b10});
    end
    checks++;
    // sw0 drops right after the tick; the synchronised stop arrives with the prescaler at 2.
    sw0 = 1'b0;
    advance(1'b1);
    advance(1'b1);
    repeat (6) begin
      advance(1'b0);
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL frozen: got %h expected %h", obs, exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_async_reset();
    do_load(4'd0, 4'd5, 4'd0, 4'd6, 4'd0, 4'd7, 1'b1);
    advance(1'b1);
    advance(1'b1);
    #3;
    rst = 1'b1;
    #1;
    exp_secs = 0;
    exp_tick = 1'b0;
    exp_wrap = 1'b0;
    if (obs !== 26'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", obs, 26'd0);
    end
    checks++;
    @(posedge clk);
    #1;
    m_hH = 4'd0; m_hL = 4'd8; m_mH = 4'd0; m_mL = 4'd9; m_sH = 4'd1; m_sL = 4'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    advance(1'b0);
    advance(1'b0);
    if (obs !== 26'd0) begin
      errors++;
      $display("FAIL pre_load_after_reset: got %h expected %h", obs, 26'd0);
    end
    checks++;
    advance(1'b0);
    k = 0;
    exp_secs = san_secs(4'd0, 4'd8, 4'd0, 4'd9, 4'd1, 4'd0);
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL load_after_reset: got %h expected %h", obs, exp_vec());
    end
    checks++;
    repeat (4) begin
      advance(1'b1);
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL run_after_reset: got %h expected %h", obs, exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_random();
    logic [3:0] hh, hl, mh, ml, sh, sl;
    int n;
    for (int i = 0; i < 8; i++) begin
      hh = 4'($urandom_range(0, 3));
      hl = 4'($urandom_range(0, 10));
      mh = 4'($urandom_range(0, 6));
      ml = 4'($urandom_range(0, 10));
      sh = 4'($urandom_range(0, 6));
      sl = 4'($urandom_range(0, 10));
      do_load(hh, hl, mh, ml, sh, sl, 1'b1);
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL rand_load_%0d: got %h expected %h", i, obs, exp_vec());
      end
      checks++;
      n = $urandom_range(4, 14);
      for (int j = 0; j < n; j++) begin
        advance(1'b1);
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL rand_run_%0d: got %h expected %h", i, obs, exp_vec());
        end
        checks++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_and_tick();
    test_day_wrap();
    test_carries();
    test_sanitise();
    test_no_load_resume();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
